// File: rtl/omp_pkg.sv
// omp_pkg: requester indices and arbiter state encoding shared by the arbiter slice
package omp_pkg;
    localparam int NREQ = 4;
    localparam logic [1:0] REQ_EXT  = 2'd0;
    localparam logic [1:0] REQ_INIT = 2'd1;
    localparam logic [1:0] REQ_A    = 2'd2;
    localparam logic [1:0] REQ_B    = 2'd3;
    typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} arb_state_e;
endpackage

// File: rtl/omp_mem_arbiter_if.sv
// omp_mem_arbiter_if: requester-side bus of the shared memory arbiter
interface omp_mem_arbiter_if #(
    parameter int AW = 7,
    parameter int DW = 96
);
    logic [omp_pkg::NREQ-1:0]    req;
    logic [omp_pkg::NREQ-1:0]    lock;
    logic [omp_pkg::NREQ-1:0]    we;
    logic [omp_pkg::NREQ*AW-1:0] addr;
    logic [omp_pkg::NREQ*DW-1:0] wdata;
    logic [omp_pkg::NREQ-1:0]    gnt;
    logic [omp_pkg::NREQ-1:0]    rvalid;
    logic [DW-1:0]               rdata;
    modport master (output req, lock, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave (input req, lock, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/omp_rr_pick.sv
// omp_rr_pick: first requesting index at or after ptr, circularly
module omp_rr_pick (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [1:0] idx_o,
    output logic       any_o
);
    always_comb begin
        idx_o = ptr_i;
        for (int k = 3; k >= 0; k--)
            if (req_i[ptr_i + 2'(k)]) idx_o = ptr_i + 2'(k);
    end
    assign any_o = |req_i;
endmodule

// File: rtl/omp_mem_arbiter.sv
// omp_mem_arbiter: round-robin arbiter with burst lock for one shared memory port,
// tagging reads through an RD_LAT-deep pipeline so data returns to its issuer.
module omp_mem_arbiter
    import omp_pkg::*;
#(
    parameter int AW     = 7,
    parameter int DW     = 96,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    omp_mem_arbiter_if.slave bus,
    input  logic             clr_err_i,
    output logic             err_o,
    output logic [AW-1:0]    mem_addr_o,
    output logic             mem_we_o,
    output logic             mem_en_o,
    output logic [DW-1:0]    mem_din_o,
    input  logic [DW-1:0]    mem_dout_i
);
    arb_state_e          state_q, state_d;
    logic [1:0]          owner_q, owner_d, rr_ptr_q, rr_ptr_d, pick_ptr, pick_idx;
    logic                pick_any, rel, rd_en, err_q, err_d;
    logic [NREQ-1:0]     gnt;
    logic [RD_LAT-1:0]   pv_q, pv_d;
    logic [2*RD_LAT-1:0] pid_q, pid_d;

    omp_rr_pick u_pick (.req_i(bus.req), .ptr_i(pick_ptr), .idx_o(pick_idx), .any_o(pick_any));

    assign gnt      = (state_q == OWNED) ? NREQ'(1) << owner_q : '0;
    assign rel      = (state_q == OWNED) && !bus.lock[owner_q];
    // On release the search starts just past the owner, so it ranks last
    assign pick_ptr = (state_q == OWNED) ? owner_q + 2'd1 : rr_ptr_q;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rel ? owner_q + 2'd1 : rr_ptr_q;
        if (state_q == IDLE || rel) begin
            state_d = pick_any ? OWNED : IDLE;
            owner_d = pick_any ? pick_idx : owner_q;
        end
    end

    assign mem_en_o   = (state_q == OWNED) && bus.req[owner_q];
    assign mem_we_o   = mem_en_o && bus.we[owner_q];
    assign mem_addr_o = mem_en_o ? bus.addr[owner_q*AW +: AW] : '0;
    assign mem_din_o  = mem_en_o ? bus.wdata[owner_q*DW +: DW] : '0;
    assign rd_en      = mem_en_o && !bus.we[owner_q];
    assign pv_d       = (pv_q << 1) | RD_LAT'(rd_en);
    assign pid_d      = (pid_q << 2) | (2*RD_LAT)'(owner_q);
    assign err_d      = (|(bus.req & bus.we & ~gnt)) || (err_q && !clr_err_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            pv_q     <= '0;
            pid_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            pv_q     <= pv_d;
            pid_q    <= pid_d;
            err_q    <= err_d;
        end
    end

    assign bus.gnt    = gnt;
    assign bus.rvalid = pv_q[RD_LAT-1] ? NREQ'(1) << pid_q[2*RD_LAT-1 -: 2] : '0;
    assign bus.rdata  = pv_q[RD_LAT-1] ? mem_dout_i : '0;
    assign err_o      = err_q;
endmodule

// File: tb/tb_omp_mem_arbiter.sv
// tb_omp_mem_arbiter: three arbiters (RD_LAT 1..3) on shared stimulus, each checked
// every cycle against a queue-based model, plus hand-computed directed expectations.
module tb_omp_mem_arbiter;
    localparam int AW = 7;
    localparam int DW = 96;

    typedef struct {int due; int id; logic [DW-1:0] data;} rd_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clr_err = 1'b0;
    logic [3:0]      req = '0, lock = '0, we = '0;
    logic [4*AW-1:0] addr = '0;
    logic [4*DW-1:0] wdata = '0;
    int              checks = 0, passed = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(int i);
        return {32'hC0DE0000 + 32'(i), 32'h12345678 ^ 32'(i), 32'(i * 7 + 1)};
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    for (genvar l = 0; l < 3; l++) begin : g_lat
        localparam int L = l + 1;
        omp_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
        logic          err, mem_we, mem_en;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] mem_din, mem_dout;
        logic [DW-1:0] mem [128];
        logic [DW-1:0] dq [3];

        assign bus.req   = req;
        assign bus.lock  = lock;
        assign bus.we    = we;
        assign bus.addr  = addr;
        assign bus.wdata = wdata;

        omp_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(L)) dut (
            .clk(clk), .rst_n(rst_n), .bus(bus), .clr_err_i(clr_err), .err_o(err),
            .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_en_o(mem_en),
            .mem_din_o(mem_din), .mem_dout_i(mem_dout)
        );

        initial for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
        always @(posedge clk) begin
            if (mem_en && mem_we) mem[mem_addr] <= mem_din;
            if (mem_en && !mem_we) dq[0] <= mem[mem_addr];
            dq[1] <= dq[0];
            dq[2] <= dq[1];
        end
        assign mem_dout = dq[L-1];

        initial begin : model
            logic [DW-1:0]  rmem [128];
            rd_t            q[$];
            bit             own, err_m, viol;
            int             o, ptr, cyc, start, a;
            logic [3:0]     exp_rv;
            logic [104:0]   exp_mem;
            for (int i = 0; i < 128; i++) rmem[i] = init_val(i);
            own = 0; err_m = 0; o = 0; ptr = 0; cyc = 0;
            forever begin
                @(negedge clk);
                cyc++;
                if (!rst_n) begin
                    own = 0; ptr = 0; err_m = 0;
                    q.delete();
                    check($sformatf("L%0d reset gnt", L), bus.gnt, 0);
                    check($sformatf("L%0d reset rvalid", L), bus.rvalid, 0);
                    check($sformatf("L%0d reset err", L), err, 0);
                end else begin
                    check($sformatf("L%0d gnt c%0d", L, cyc), bus.gnt, own ? 4'(1 << o) : 4'd0);
                    exp_rv = 0;
                    if (q.size() > 0 && q[0].due == cyc) begin
                        exp_rv = 4'(1 << q[0].id);
                        check($sformatf("L%0d rdata c%0d", L, cyc), bus.rdata, q[0].data);
                        void'(q.pop_front());
                    end
                    check($sformatf("L%0d rvalid c%0d", L, cyc), bus.rvalid, exp_rv);
                    exp_mem = (own && req[o]) ? {1'b1, we[o], addr[o*AW +: AW], wdata[o*DW +: DW]} : '0;
                    check($sformatf("L%0d mem port c%0d", L, cyc), {mem_en, mem_we, mem_addr, mem_din}, exp_mem);
                    check($sformatf("L%0d err c%0d", L, cyc), err, err_m);
                    if (own && req[o]) begin
                        a = int'(addr[o*AW +: AW]);
                        if (we[o]) rmem[a] = wdata[o*DW +: DW];
                        else q.push_back('{cyc + L, o, rmem[a]});
                    end
                    viol = 0;
                    for (int i = 0; i < 4; i++) if (req[i] && we[i] && !(own && o == i)) viol = 1;
                    err_m = viol || (err_m && !clr_err);
                    if (!own || !lock[o]) begin
                        start = own ? (o + 1) % 4 : ptr;
                        if (own) ptr = start;
                        own = 0;
                        for (int k = 0; k < 4; k++)
                            if (!own && req[(start + k) % 4]) begin own = 1; o = (start + k) % 4; end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_rq(int i, logic [AW-1:0] a, logic w, logic [DW-1:0] d);
        addr[i*AW +: AW]  = a;
        we[i]             = w;
        wdata[i*DW +: DW] = d;
    endtask

    initial begin
        logic [3:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 4; i++) set_rq(i, AW'(10 + i), 1'b0, init_val(100 + i));
        repeat (3) step();
        // full request set rotates one grant per cycle
        rst_n = 1'b1; req = 4'b1111;
        @(negedge clk); check("gnt before first edge", g_lat[0].bus.gnt, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            step(); @(negedge clk);
            check($sformatf("rotation gnt %0d", k), g_lat[0].bus.gnt, seq[k]);
        end
        step(); req = 4'b0000; repeat (4) step();
        // locked burst by block A with block B pending
        set_rq(2, 7'd5, 1'b0, '0); req = 4'b0100; lock = 4'b0100; step();
        req = 4'b1100; set_rq(3, 7'd20, 1'b0, '0);
        @(negedge clk); check("lock gnt c1", g_lat[0].bus.gnt, 4'b0100); step();
        set_rq(2, 7'd6, 1'b0, '0);
        @(negedge clk); check("burst rvalid 1", g_lat[0].bus.rvalid, 4'b0100);
        check("burst rdata 1", g_lat[0].bus.rdata, init_val(5)); step();
        set_rq(2, 7'd7, 1'b0, '0);
        @(negedge clk); check("burst rvalid 2", g_lat[0].bus.rvalid, 4'b0100);
        check("burst rdata 2", g_lat[0].bus.rdata, init_val(6)); step();
        req = 4'b1000; lock = 4'b0000;
        @(negedge clk); check("lock gnt held", g_lat[0].bus.gnt, 4'b0100);
        check("burst rvalid 3", g_lat[0].bus.rvalid, 4'b0100);
        check("burst rdata 3", g_lat[0].bus.rdata, init_val(7)); step();
        req = 4'b0000;
        @(negedge clk); check("handover gnt", g_lat[0].bus.gnt, 4'b1000);
        check("burst no 4th rvalid", g_lat[0].bus.rvalid, 4'b0000); step();
        repeat (4) step();
        // read completes after the grant moved on
        set_rq(1, 7'd3, 1'b0, '0); set_rq(3, 7'd30, 1'b0, init_val(999)); req = 4'b1010; step();
        @(negedge clk); check("lat2 gnt req1", g_lat[1].bus.gnt, 4'b0010); step();
        req = 4'b1000; set_rq(3, 7'd30, 1'b1, init_val(999));
        @(negedge clk); check("lat2 gnt req3", g_lat[1].bus.gnt, 4'b1000);
        check("lat2 rvalid early", g_lat[1].bus.rvalid, 4'b0000);
        check("lat1 rvalid", g_lat[0].bus.rvalid, 4'b0010);
        check("lat1 rdata", g_lat[0].bus.rdata, init_val(3)); step();
        req = 4'b0000; set_rq(3, 7'd30, 1'b0, '0);
        @(negedge clk); check("lat2 rvalid", g_lat[1].bus.rvalid, 4'b0010);
        check("lat2 rdata", g_lat[1].bus.rdata, init_val(3));
        check("lat3 rvalid early", g_lat[2].bus.rvalid, 4'b0000); step();
        @(negedge clk); check("lat3 rvalid", g_lat[2].bus.rvalid, 4'b0010);
        check("lat3 rdata", g_lat[2].bus.rdata, init_val(3));
        check("granted write landed", g_lat[0].mem[30], init_val(999)); step();
        repeat (3) step();
        // ungranted write is dropped and flags err
        set_rq(0, 7'd40, 1'b0, '0); req = 4'b0001; lock = 4'b0001; step();
        set_rq(3, 7'd9, 1'b1, init_val(777)); req = 4'b1001;
        @(negedge clk); check("owner0 gnt", g_lat[0].bus.gnt, 4'b0001);
        check("err before violation", g_lat[0].err, 1'b0); step();
        req = 4'b0001; set_rq(3, 7'd9, 1'b0, '0);
        @(negedge clk); check("err set", g_lat[0].err, 1'b1);
        check("mem9 untouched", g_lat[0].mem[9], init_val(9)); step();
        clr_err = 1'b1;
        @(negedge clk); check("err sticky", g_lat[0].err, 1'b1); step();
        req = 4'b1001; set_rq(3, 7'd9, 1'b1, init_val(777));
        @(negedge clk); check("err cleared", g_lat[0].err, 1'b0); step();
        clr_err = 1'b0; req = 4'b0001; set_rq(3, 7'd9, 1'b0, '0);
        @(negedge clk); check("err set wins over clear", g_lat[0].err, 1'b1); step();
        clr_err = 1'b1; step();
        clr_err = 1'b0; req = 4'b0000; lock = 4'b0000;
        @(negedge clk); check("err cleared again", g_lat[0].err, 1'b0);
        check("mem9 still untouched", g_lat[2].mem[9], init_val(9)); step();
        repeat (4) step();
        // reset during an RD_LAT=3 burst
        set_rq(2, 7'd50, 1'b0, '0); req = 4'b0100; lock = 4'b0100; step();
        set_rq(2, 7'd51, 1'b0, '0); step();
        set_rq(2, 7'd52, 1'b0, '0); step();
        rst_n = 1'b0;
        @(negedge clk); check("async rst gnt L3", g_lat[2].bus.gnt, 4'b0000);
        check("async rst rvalid L3", g_lat[2].bus.rvalid, 4'b0000);
        check("async rst rvalid L1", g_lat[0].bus.rvalid, 4'b0000); step();
        @(negedge clk); check("rst rvalid L3 held", g_lat[2].bus.rvalid, 4'b0000); step();
        rst_n = 1'b1; req = 4'b1110; lock = 4'b0000;
        @(negedge clk); check("no grant before edge", g_lat[2].bus.gnt, 4'b0000); step();
        req = 4'b0000;
        @(negedge clk); check("first grant lowest idx", g_lat[2].bus.gnt, 4'b0010); step();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); check($sformatf("no stale rvalid %0d", k), g_lat[2].bus.rvalid, 4'b0000); step();
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
